vec_mul_pipe: RTL
=================

Name: vec_mul_pipe

Overview:
Parametrised successor to the single-stage vector multiplier. It performs a lane-wise signed multiply of two joined input vector streams with full valid/ready backpressure through a configurable-depth pipeline. Each product is arithmetically right-shifted and narrowed to the output width. It sits between the feature/weight streams and the adder tree in the word-recognition datapath.

Parameters:
I_BW, 8, input element bitwidth (signed)
O_BW, 16, output element bitwidth (signed), 2 <= O_BW <= 2*I_BW
VECTOR_LEN, 13, number of lanes
PIPE_DEPTH, 2, register stages from input transfer to output, >= 1
SHIFT, 0, arithmetic right shift applied to each 2*I_BW product, 0 <= SHIFT < 2*I_BW

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
data0_i  in  VECTOR_LEN*I_BW  stream 0 vector, lane i at bits [(i+1)*I_BW-1 : i*I_BW]
valid0_i  in  1  stream 0 valid
last0_i  in  1  stream 0 end-of-frame
ready0_o  out  1  stream 0 ready
data1_i  in  VECTOR_LEN*I_BW  stream 1 vector, same packing
valid1_i  in  1  stream 1 valid
last1_i  in  1  stream 1 end-of-frame
ready1_o  out  1  stream 1 ready
data_o  out  VECTOR_LEN*O_BW  result vector, lane i at bits [(i+1)*O_BW-1 : i*O_BW]
valid_o  out  1  result valid
last_o  out  1  result end-of-frame
ready_i  in  1  downstream ready
err_o  out  1  sticky last-mismatch flag

Behaviour:
- Reset (rst_i asynchronous, active-high): all stage valid bits, data, last and err registers clear to 0. valid_o=0, last_o=0, data_o=0, err_o=0. ready0_o/ready1_o read 1 once the pipeline is empty. Reset mid-stream discards all in-flight beats.
- Stage k (0..PIPE_DEPTH-1) holds a valid bit, VECTOR_LEN results and a last bit. The last stage drives data_o/valid_o/last_o directly from registers.
- Stage advance: accept[PIPE_DEPTH-1] = !v[PIPE_DEPTH-1] | ready_i; accept[k] = !v[k] | accept[k+1]. A stage loads from upstream when accept[k] is true, and its valid bit takes the upstream valid.
- ready0_o = ready1_o = accept[0]. This is combinational from ready_i and the valid bits, and never depends on valid0_i/valid1_i.
- Input transfer (join) happens only when valid0_i & valid1_i & accept[0]. A lone valid never transfers and is held off.
- Latency: PIPE_DEPTH cycles from transfer to valid_o, with no bubbles. Throughput is 1 beat/cycle while ready_i=1.
- Output hold: when valid_o=1 and ready_i=0, data_o/last_o stay stable until the handshake completes. Order is preserved and no beat is dropped or duplicated.
- Arithmetic (computed in stage 0):
  - p = signed(data0 lane) * signed(data1 lane), 2*I_BW bits, exact.
  - s = p >>> SHIFT (arithmetic).
  - Narrow s to O_BW per Optional Feature. When O_BW >= 2*I_BW-SHIFT, s is sign-extended and no overflow is possible.
- last: transferred beat's last = last0_i | last1_i.
- err_o: set on the cycle after any transfer with last0_i != last1_i. It stays 1 until reset.

Optional Feature:
VEC_MUL_SAT_EN. Defined: each lane saturates to [-2^(O_BW-1), 2^(O_BW-1)-1] when s overflows O_BW. Undefined: each lane takes s[O_BW-1:0] (two's-complement wrap). The handshake, latency and err_o are identical in both builds.

Test Plan:
1. Defaults, single transfer with all lanes data0=-128, data1=-128 (lane 3: 127 and -128): valid_o high exactly 2 cycles after transfer. Lanes = 16384, lane 3 = -16256. last_o matches input. err_o=0.
2. Join: valid0_i=1, valid1_i=0 for 3 cycles -> no transfer, valid_o stays 0. Raise valid1_i -> exactly one beat out after 2 cycles.
3. Backpressure: 6 consecutive beats (lane0 = 1..6 times 1) with ready_i=0 from cycle 3 for 5 cycles:
   - ready0_o/ready1_o drop after 2 beats are buffered.
   - data_o holds 1 while stalled.
   - After release, outputs are 1,2,3,4,5,6 in order, with no loss or duplicates.
4. O_BW=8, SHIFT=0:
   - -128*-128 -> 127 with VEC_MUL_SAT_EN, 0 without.
   - 100*100 -> 127 / 16.
   - -100*100 -> -128 / -16.
   - SHIFT=4, 100*100 -> 625 -> 127 / 113.
5. last0_i=1, last1_i=0 on a transfer -> last_o=1 on that output beat. err_o=1 from the next cycle, and stays 1 through 10 further matched beats.
6. Assert rst_i asynchronously with 2 beats in flight and ready_i=0 -> valid_o, last_o, err_o, data_o read 0 immediately (before the next edge). ready0_o reads 1 after release. No stale beat emerges.

Source files
------------

// File: rtl/vec_mul_pipe.sv
// Lane-wise signed vector multiplier with joined input streams, valid/ready backpressure and PIPE_DEPTH stages.
// Define VEC_MUL_SAT_EN to saturate narrowed lanes; otherwise lanes wrap (two's complement).
module vec_mul_pipe #(
  parameter int I_BW       = 8,
  parameter int O_BW       = 16,
  parameter int VECTOR_LEN = 13,
  parameter int PIPE_DEPTH = 2,
  parameter int SHIFT      = 0
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [VECTOR_LEN*I_BW-1:0]   data0_i,
  input  logic                         valid0_i,
  input  logic                         last0_i,
  output logic                         ready0_o,
  input  logic [VECTOR_LEN*I_BW-1:0]   data1_i,
  input  logic                         valid1_i,
  input  logic                         last1_i,
  output logic                         ready1_o,
  output logic [VECTOR_LEN*O_BW-1:0]   data_o,
  output logic                         valid_o,
  output logic                         last_o,
  input  logic                         ready_i,
  output logic                         err_o
);

  localparam int P_BW = 2 * I_BW;
  localparam int D_BW = VECTOR_LEN * O_BW;

  logic [D_BW-1:0]       lane_res;
  logic [D_BW-1:0]       stage_data [PIPE_DEPTH];
  logic [PIPE_DEPTH-1:0] stage_valid;
  logic [PIPE_DEPTH-1:0] stage_last;
  logic [PIPE_DEPTH-1:0] accept;
  logic                  in_valid;
  logic                  xfer;
  logic                  err_reg;

  assign in_valid = valid0_i & valid1_i;
  assign xfer     = in_valid & accept[0];

  genvar gi;

  // Per-lane multiply, arithmetic shift and narrowing (all feeding stage 0).
  for (gi = 0; gi < VECTOR_LEN; gi++) begin : g_lane
    logic signed [I_BW-1:0] a;
    logic signed [I_BW-1:0] b;
    logic signed [P_BW-1:0] prod;
    logic signed [P_BW-1:0] shifted;
    logic        [O_BW-1:0] narrow;

    assign a       = data0_i[gi*I_BW +: I_BW];
    assign b       = data1_i[gi*I_BW +: I_BW];
    assign prod    = P_BW'(a) * P_BW'(b);
    assign shifted = prod >>> SHIFT;

`ifdef VEC_MUL_SAT_EN
    // Fits in O_BW only if every bit from O_BW-1 upward matches the sign.
    logic [P_BW-O_BW:0] hi;
    logic               fits;
    assign hi   = shifted[P_BW-1:O_BW-1];
    assign fits = (&hi) | (~|hi);
    always_comb begin
      narrow = O_BW'(shifted);
      if (!fits) begin
        narrow = shifted[P_BW-1] ? {1'b1, {(O_BW-1){1'b0}}}
                                 : {1'b0, {(O_BW-1){1'b1}}};
      end
    end
`else
    assign narrow = O_BW'(shifted);
`endif

    assign lane_res[gi*O_BW +: O_BW] = narrow;
  end

  // A stage may load when it is empty or the stage after it is moving.
  assign accept[PIPE_DEPTH-1] = ~stage_valid[PIPE_DEPTH-1] | ready_i;
  for (gi = 0; gi < PIPE_DEPTH - 1; gi++) begin : g_accept
    assign accept[gi] = ~stage_valid[gi] | accept[gi+1];
  end

  for (gi = 0; gi < PIPE_DEPTH; gi++) begin : g_stage
    logic            v_reg;
    logic            last_reg;
    logic [D_BW-1:0] data_reg;
    logic            up_valid;
    logic            up_last;
    logic [D_BW-1:0] up_data;

    if (gi == 0) begin : g_src
      assign up_valid = in_valid;
      assign up_last  = last0_i | last1_i;
      assign up_data  = lane_res;
    end else begin : g_src
      assign up_valid = stage_valid[gi-1];
      assign up_last  = stage_last[gi-1];
      assign up_data  = stage_data[gi-1];
    end

    // Payload only captured with a valid beat so idle stages keep quiet.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        v_reg    <= 1'b0;
        last_reg <= 1'b0;
        data_reg <= '0;
      end else if (accept[gi]) begin
        v_reg <= up_valid;
        if (up_valid) begin
          last_reg <= up_last;
          data_reg <= up_data;
        end
      end
    end

    assign stage_valid[gi] = v_reg;
    assign stage_last[gi]  = last_reg;
    assign stage_data[gi]  = data_reg;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_reg <= 1'b0;
    end else if (xfer && (last0_i != last1_i)) begin
      err_reg <= 1'b1;
    end
  end

  assign ready0_o = accept[0];
  assign ready1_o = accept[0];
  assign data_o   = stage_data[PIPE_DEPTH-1];
  assign valid_o  = stage_valid[PIPE_DEPTH-1];
  assign last_o   = stage_last[PIPE_DEPTH-1];
  assign err_o    = err_reg;

endmodule
